// File: rtl/pipe_elastic_reg_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
package pipe_pkg;

  // Upper bound on the number of register slots a chain may be built with.
  localparam int PIPE_MAX_STAGES = 8;

  // Global pipeline controls, bundled so they travel together.
  typedef struct packed {
    logic halt;   // CPU halted: freeze everything
    logic stall;  // hazard stall: freeze everything
    logic flush;  // kill all in-flight entries
  } pipe_ctrl_t;

  // Width of a counter able to hold 0..stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_elastic_reg_if.sv
// Valid/ready/data handshake bundle. The producer of the payload uses the
// master modport, the consumer uses the slave modport.
interface pipe_elastic_reg_if #(
  parameter int WIDTH = 9
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  // Payload producer: drives valid/data, observes ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Payload consumer: observes valid/data, drives ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface : pipe_elastic_reg_if

// File: rtl/pipe_elastic_reg_slot.sv
// One slot of the elastic chain: a valid bit plus a payload register.
// Clear wins over load. Loading an empty entry only updates the valid bit;
// the payload is left untouched so an idle slot does not toggle.
module pipe_slot #(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Slot state: async reset, then clear, then load, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (ld_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : pipe_slot

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register chain: STAGES valid+payload slots between two
// valid/ready interfaces, with global halt/stall (freeze) and flush.
// Bubbles collapse: a slot may accept new data whenever it is empty or its
// contents move on in the same cycle, so the chain fills completely before
// back-pressuring upstream.
//
// Timing note: out_if.ready reaches in_if.ready through the advance chain
// (a combinational path of STAGES levels). There is no combinational path
// from in_if.valid to out_if.valid; out_* come straight from slot flops.
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 9,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           halt,
  input  logic                           stall,
  input  logic                           flush,
  pipe_elastic_reg_if.slave              in_if,
  pipe_elastic_reg_if.master             out_if,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  pipe_ctrl_t                   ctrl_s;
  logic                         freeze_s;
  logic                         in_ready_s;

  // Per-slot state as seen from the slot registers.
  logic [STAGES-1:0]            valid_s;
  logic [STAGES-1:0][WIDTH-1:0] data_s;

  // adv_s[i]: slot i's contents leave this cycle (if it holds anything).
  // take_s[i]: slot i can be written this cycle (empty or draining).
  logic [STAGES-1:0]            adv_s;
  logic [STAGES-1:0]            take_s;

  // What each slot would load, and whether it loads.
  logic [STAGES-1:0]            ld_s;
  logic [STAGES-1:0]            src_valid_s;
  logic [STAGES-1:0][WIDTH-1:0] src_data_s;

  // Valid vector after the coming edge, used for the occupancy count.
  logic [STAGES-1:0]            nxt_valid_s;
  logic [OCC_W-1:0]             occupancy_d;
  logic [OCC_W-1:0]             occupancy_q;

  assign ctrl_s   = '{halt: halt, stall: stall, flush: flush};
  assign freeze_s = ctrl_s.halt | ctrl_s.stall;

  // Advance/take chain, walked from the output slot back to the input slot.
  always_comb begin
    logic next_take;
    adv_s     = '0;
    take_s    = '0;
    next_take = out_if.ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv_s[i]  = !freeze_s & next_take;
      take_s[i] = !valid_s[i] | adv_s[i];
      next_take = take_s[i];
    end
  end

  // Upstream may hand over data only when slot 0 can take it and nothing
  // is frozen or being flushed.
  assign in_ready_s = !ctrl_s.flush & !freeze_s & take_s[0];

  // Slot sources: slot 0 from upstream, every other slot from its predecessor.
  always_comb begin
    src_valid_s    = '0;
    src_data_s     = '0;
    src_valid_s[0] = in_if.valid & in_ready_s;
    src_data_s[0]  = in_if.data;
    for (int i = 1; i < STAGES; i++) begin
      src_valid_s[i] = valid_s[i-1];
      src_data_s[i]  = data_s[i-1];
    end
  end

  // A slot loads whenever it can take data and the chain is not frozen;
  // loading an invalid source is how a drained slot becomes empty.
  always_comb begin
    ld_s = '0;
    for (int i = 0; i < STAGES; i++) begin
      ld_s[i] = !freeze_s & take_s[i];
    end
  end

  // Register slots; flush clears every slot regardless of freeze.
  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (ctrl_s.flush),
      .ld_i    (ld_s[g]),
      .valid_i (src_valid_s[g]),
      .data_i  (src_data_s[g]),
      .valid_o (valid_s[g]),
      .data_o  (data_s[g])
    );
  end

  // Predict the post-edge valid vector the same way the slots will update.
  always_comb begin
    nxt_valid_s = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (ctrl_s.flush) begin
        nxt_valid_s[i] = 1'b0;
      end else if (ld_s[i]) begin
        nxt_valid_s[i] = src_valid_s[i];
      end else begin
        nxt_valid_s[i] = valid_s[i];
      end
    end
  end

  // Popcount of the post-edge valid vector.
  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_d = occupancy_d + OCC_W'(nxt_valid_s[i]);
    end
  end

  // Occupancy register, updated on the same edge as the slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign in_if.ready  = in_ready_s;
  assign out_if.valid = valid_s[STAGES-1];
  assign out_if.data  = data_s[STAGES-1];
  assign occupancy    = occupancy_q;

endmodule : pipe_elastic_reg

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg: a 3-slot chain for the directed
// scenarios and a 1-slot chain driven against a small scoreboard.
module tb_pipe_elastic_reg;

  localparam logic [8:0] RV3 = 9'h1A5;

  logic       clk = 1'b0;
  logic       reset;
  logic       halt;
  logic       stall;
  logic       flush;
  logic [1:0] occ_a;
  logic [0:0] occ_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_elastic_reg_if #(.WIDTH(9)) a_in ();
  pipe_elastic_reg_if #(.WIDTH(9)) a_out ();
  pipe_elastic_reg_if #(.WIDTH(9)) b_in ();
  pipe_elastic_reg_if #(.WIDTH(9)) b_out ();

  pipe_elastic_reg #(.WIDTH(9), .STAGES(3), .RESET_VAL(RV3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .halt      (halt),
    .stall     (stall),
    .flush     (flush),
    .in_if     (a_in),
    .out_if    (a_out),
    .occupancy (occ_a)
  );

  pipe_elastic_reg #(.WIDTH(9), .STAGES(1), .RESET_VAL(9'h000)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .halt      (halt),
    .stall     (stall),
    .flush     (flush),
    .in_if     (b_in),
    .out_if    (b_out),
    .occupancy (occ_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] q[$];
  logic       m_valid;
  logic       exp_rdy;
  logic [8:0] nxt_word;

  initial begin
    reset = 1'b1; halt = 1'b0; stall = 1'b0; flush = 1'b0;
    a_in.valid = 1'b0; a_in.data = 9'h000; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = 9'h000; b_out.ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("rst_out_valid", a_out.valid, 1'b0);
    check_eq("rst_out_data", a_out.data, RV3);
    check_eq("rst_occ", occ_a, 2'd0);
    check_eq("rst_in_ready", a_in.ready, 1'b1);
    check_eq("rst_b_out_data", b_out.data, 9'h000);

    // Latency and throughput with out_ready=1
    a_out.ready = 1'b1;
    a_in.valid = 1'b1; a_in.data = 9'h001; tick();
    check_eq("lat_occ1", occ_a, 2'd1);
    check_eq("lat_ov1", a_out.valid, 1'b0);
    a_in.data = 9'h002; tick();
    check_eq("lat_occ2", occ_a, 2'd2);
    check_eq("lat_ov2", a_out.valid, 1'b0);
    a_in.data = 9'h003; tick();
    check_eq("lat_occ3", occ_a, 2'd3);
    check_eq("lat_ov3", a_out.valid, 1'b1);
    check_eq("lat_d3", a_out.data, 9'h001);
    a_in.valid = 1'b0; tick();
    check_eq("lat_d4", a_out.data, 9'h002);
    check_eq("lat_occ4", occ_a, 2'd2);
    tick();
    check_eq("lat_d5", a_out.data, 9'h003);
    check_eq("lat_occ5", occ_a, 2'd1);
    tick();
    check_eq("lat_ov6", a_out.valid, 1'b0);
    check_eq("lat_occ6", occ_a, 2'd0);

    // Back-pressure: fill to 3, then drain while the 4th goes in
    a_out.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in.valid = 1'b1; a_in.data = 9'h0A0 + 9'(k);
      #1 check_eq("bp_in_ready", a_in.ready, 1'b1);
      tick();
    end
    a_in.data = 9'h0A3;
    #1;
    check_eq("bp_full_in_ready", a_in.ready, 1'b0);
    check_eq("bp_full_occ", occ_a, 2'd3);
    check_eq("bp_head", a_out.data, 9'h0A0);
    a_out.ready = 1'b1;
    #1 check_eq("bp_ready_path", a_in.ready, 1'b1);
    tick();
    a_in.valid = 1'b0;
    check_eq("bp_d1", a_out.data, 9'h0A1);
    check_eq("bp_occ_keep", occ_a, 2'd3);
    tick();
    check_eq("bp_d2", a_out.data, 9'h0A2);
    check_eq("bp_occ2", occ_a, 2'd2);
    tick();
    check_eq("bp_d3", a_out.data, 9'h0A3);
    check_eq("bp_occ1", occ_a, 2'd1);
    tick();
    check_eq("bp_empty", a_out.valid, 1'b0);
    check_eq("bp_occ0", occ_a, 2'd0);

    // Stall on a full chain
    a_out.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in.valid = 1'b1; a_in.data = 9'h0B0 + 9'(k);
      tick();
    end
    stall = 1'b1; a_out.ready = 1'b1; a_in.data = 9'h1FF;
    for (int k = 0; k < 5; k++) begin
      #1 check_eq("st_in_ready", a_in.ready, 1'b0);
      tick();
      check_eq("st_ov", a_out.valid, 1'b1);
      check_eq("st_head", a_out.data, 9'h0B0);
      check_eq("st_occ", occ_a, 2'd3);
    end
    stall = 1'b0; a_in.valid = 1'b0;
    tick();
    check_eq("st_d1", a_out.data, 9'h0B1);
    tick();
    check_eq("st_d2", a_out.data, 9'h0B2);
    tick();
    check_eq("st_empty", a_out.valid, 1'b0);
    check_eq("st_occ0", occ_a, 2'd0);

    // Flush together with halt, two entries in flight
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 9'h0C0; tick();
    a_in.data = 9'h0C1; tick();
    a_in.valid = 1'b0;
    check_eq("fl_occ_pre", occ_a, 2'd2);
    flush = 1'b1; halt = 1'b1; a_in.valid = 1'b1; a_in.data = 9'h0C7; a_out.ready = 1'b1;
    #1 check_eq("fl_in_ready", a_in.ready, 1'b0);
    tick();
    flush = 1'b0; halt = 1'b0; a_in.valid = 1'b0;
    check_eq("fl_occ", occ_a, 2'd0);
    check_eq("fl_ov", a_out.valid, 1'b0);
    check_eq("fl_data", a_out.data, RV3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("fl_nocapture", a_out.valid, 1'b0);
    end

    // Async reset between edges with two entries
    a_out.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in.valid = 1'b1; a_in.data = 9'h0D0 + 9'(k);
      tick();
    end
    a_in.valid = 1'b0; a_out.ready = 1'b1;
    tick();
    a_out.ready = 1'b0;
    check_eq("ar_occ_pre", occ_a, 2'd2);
    check_eq("ar_ov_pre", a_out.valid, 1'b1);
    check_eq("ar_d_pre", a_out.data, 9'h0D1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_ov", a_out.valid, 1'b0);
    check_eq("ar_occ", occ_a, 2'd0);
    check_eq("ar_data", a_out.data, RV3);
    tick();
    #2 reset = 1'b0;
    a_in.valid = 1'b1; a_in.data = 9'h0E0; a_out.ready = 1'b1;
    #1 check_eq("ar_in_ready", a_in.ready, 1'b1);
    tick();
    a_in.valid = 1'b0;
    check_eq("ar_lat1", a_out.valid, 1'b0);
    tick();
    check_eq("ar_lat2", a_out.valid, 1'b0);
    tick();
    check_eq("ar_lat3", a_out.valid, 1'b1);
    check_eq("ar_lat3_d", a_out.data, 9'h0E0);
    tick();

    // Single-slot chain against a scoreboard
    m_valid = 1'b0;
    nxt_word = 9'h010;
    for (int i = 0; i < 200; i++) begin
      b_in.valid = (i % 2 == 0) || ($urandom_range(0, 3) == 0);
      b_in.data = nxt_word;
      b_out.ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !m_valid | b_out.ready;
      check_eq("s1_in_ready", b_in.ready, exp_rdy);
      check_eq("s1_out_valid", b_out.valid, m_valid);
      check_eq("s1_occ", occ_b, m_valid);
      if (m_valid) begin
        check_eq("s1_out_data", b_out.data, q[0]);
        if (b_out.ready) begin
          void'(q.pop_front());
        end
      end
      if (exp_rdy) begin
        if (b_in.valid) begin
          q.push_back(b_in.data);
          nxt_word = nxt_word + 9'd1;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      tick();
    end
    check_eq("s1_q_size", q.size(), {31'd0, m_valid});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_elastic_reg
